// File: rtl/effects_pkg.sv
// Shared types and helpers for the audio effect blocks: compression ratio
// encoding, level-to-threshold/makeup lookup and unsigned saturation.
package effects_pkg;

  typedef enum logic [1:0] {
    RATIO_2_1   = 2'd0,
    RATIO_4_1   = 2'd1,
    RATIO_8_1   = 2'd2,
    RATIO_LIMIT = 2'd3
  } ratio_e;

  // Threshold is expressed for a 16-bit sample; callers scale it to their width.
  typedef struct packed {
    logic [14:0] threshold;
    logic [1:0]  makeup;
  } level_cfg_t;

  localparam int SAT_W = 32;

  function automatic level_cfg_t level_cfg(input logic [2:0] level);
    level_cfg_t cfg;
    case (level)
      3'd0:    cfg = '{threshold: 15'd28000, makeup: 2'd0};
      3'd1:    cfg = '{threshold: 15'd24000, makeup: 2'd0};
      3'd2:    cfg = '{threshold: 15'd20000, makeup: 2'd0};
      3'd3:    cfg = '{threshold: 15'd16000, makeup: 2'd1};
      3'd4:    cfg = '{threshold: 15'd12000, makeup: 2'd1};
      3'd5:    cfg = '{threshold: 15'd8000,  makeup: 2'd2};
      3'd6:    cfg = '{threshold: 15'd4000,  makeup: 2'd2};
      default: cfg = '{threshold: 15'd2000,  makeup: 2'd3};
    endcase
    return cfg;
  endfunction

  // Clamp an unsigned value to an upper limit.
  function automatic logic [SAT_W-1:0] saturate_u(input logic [SAT_W-1:0] value,
                                                  input logic [SAT_W-1:0] limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/comp_env_follower.sv
// Per-channel peak envelope store. The update for the presented channel is
// computed combinationally and written back at the same clock edge, so a
// sample on the same channel in the very next cycle reads the new value.
module comp_env_follower
  import effects_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int NUM_CH    = 2,
  parameter int ATK_SHIFT = 2,
  parameter int REL_SHIFT = 6,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [CH_W-1:0]   i_ch,
  input  logic [DATA_W-2:0] i_amp,
  output logic [DATA_W-2:0] o_env
);

  logic [DATA_W-2:0] env_q [NUM_CH];
  logic [DATA_W-2:0] env_d [NUM_CH];
  logic [DATA_W-2:0] env_cur;
  logic [DATA_W-2:0] env_new;

  // Attack toward louder input quickly, release toward quieter input slowly.
  always_comb begin
    env_cur = env_q[i_ch];
    if (i_amp > env_cur) begin
      env_new = env_cur + ((i_amp - env_cur) >> ATK_SHIFT);
    end else begin
      env_new = env_cur - ((env_cur - i_amp) >> REL_SHIFT);
    end
  end

  // Only the addressed channel changes, and only for an accepted sample.
  always_comb begin
    env_d = env_q;
    if (i_valid) begin
      env_d[i_ch] = env_new;
    end
  end

  // Envelope storage with synchronous clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        env_q[c] <= '0;
      end
    end else begin
      env_q <= env_d;
    end
  end

  assign o_env = env_new;

endmodule

// File: rtl/effect_dyn_compressor.sv
// Three-stage dynamic range compressor for interleaved multi-channel audio.
// Stage 1 rectifies and captures controls, stage 2 updates the channel
// envelope, stage 3 applies threshold/ratio reduction, makeup gain and sign.
module effect_dyn_compressor
  import effects_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int NUM_CH    = 2,
  parameter int ATK_SHIFT = 2,
  parameter int REL_SHIFT = 6,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  input  logic [CH_W-1:0]          i_ch,
  input  logic                     i_enable,
  input  logic [2:0]               i_level,
  input  logic [1:0]               i_ratio,
  input  logic                     i_link,
  input  logic signed [DATA_W-1:0] i_data,
  output logic signed [DATA_W-1:0] o_data,
  output logic                     o_valid,
  output logic [CH_W-1:0]          o_ch
);

  localparam logic [DATA_W-2:0] AMP_MAX  = '1;
  localparam logic [CH_W:0]     NUM_CH_L = (CH_W+1)'(NUM_CH);

  typedef struct packed {
    logic                     valid;
    logic [CH_W-1:0]          ch;
    logic signed [DATA_W-1:0] data;
    logic [DATA_W-2:0]        amp;
    logic                     enable;
    logic [2:0]               level;
    ratio_e                   ratio;
    logic                     link;
  } s1_t;

  typedef struct packed {
    logic                     valid;
    logic [CH_W-1:0]          ch;
    logic signed [DATA_W-1:0] data;
    logic [DATA_W-2:0]        amp;
    logic                     enable;
    logic [2:0]               level;
    ratio_e                   ratio;
    logic [DATA_W-2:0]        env;
  } s2_t;

  typedef struct packed {
    logic                     valid;
    logic [CH_W-1:0]          ch;
    logic signed [DATA_W-1:0] data;
  } out_t;

  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;
  out_t out_q, out_d;

  logic              accept;
  logic [DATA_W-1:0] in_mag;
  logic [CH_W-1:0]   env_ch;
  logic [DATA_W-2:0] env_upd;

  level_cfg_t        cfg;
  logic [DATA_W-2:0] thr;
  logic [DATA_W-2:0] over;
  logic [DATA_W-2:0] red;
  logic [DATA_W-2:0] reduced;
  logic [DATA_W+1:0] boosted;
  logic [DATA_W-2:0] mag_out;
  logic [DATA_W-1:0] pos_val;
  logic [DATA_W-1:0] comp_val;

  // Samples addressed to a channel that does not exist are dropped entirely.
  assign accept = i_valid && ({1'b0, i_ch} < NUM_CH_L);

  // In link mode every channel shares the channel-0 envelope.
  assign env_ch = s1_q.link ? '0 : s1_q.ch;

  // Stage 1: rectify (most negative input clamps to full scale) and capture controls.
  always_comb begin
    s1_d       = s1_q;
    s1_d.valid = accept;
    in_mag     = i_data[DATA_W-1] ? DATA_W'(-i_data) : DATA_W'(i_data);
    if (accept) begin
      s1_d.ch     = i_ch;
      s1_d.data   = i_data;
      s1_d.amp    = (DATA_W-1)'(saturate_u(SAT_W'(in_mag), SAT_W'(AMP_MAX)));
      s1_d.enable = i_enable;
      s1_d.level  = i_level;
      s1_d.ratio  = ratio_e'(i_ratio);
      s1_d.link   = i_link;
    end
  end

  comp_env_follower #(
    .DATA_W    (DATA_W),
    .NUM_CH    (NUM_CH),
    .ATK_SHIFT (ATK_SHIFT),
    .REL_SHIFT (REL_SHIFT)
  ) u_env (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (s1_q.valid),
    .i_ch    (env_ch),
    .i_amp   (s1_q.amp),
    .o_env   (env_upd)
  );

  // Stage 2: carry the sample forward together with its freshly updated envelope.
  always_comb begin
    s2_d       = s2_q;
    s2_d.valid = s1_q.valid;
    if (s1_q.valid) begin
      s2_d.ch     = s1_q.ch;
      s2_d.data   = s1_q.data;
      s2_d.amp    = s1_q.amp;
      s2_d.enable = s1_q.enable;
      s2_d.level  = s1_q.level;
      s2_d.ratio  = s1_q.ratio;
      s2_d.env    = env_upd;
    end
  end

  // Stage 3: gain computation; the output register holds between strobes.
  always_comb begin
    cfg  = level_cfg(s2_q.level);
    thr  = (DATA_W-1)'(cfg.threshold) << (DATA_W-16);
    over = (s2_q.env > thr) ? (s2_q.env - thr) : '0;
    case (s2_q.ratio)
      RATIO_2_1: red = over - (over >> 1);
      RATIO_4_1: red = over - (over >> 2);
      RATIO_8_1: red = over - (over >> 3);
      default:   red = over;
    endcase
    reduced  = (s2_q.amp > red) ? (s2_q.amp - red) : '0;
    boosted  = (DATA_W+2)'(reduced) << cfg.makeup;
    mag_out  = (DATA_W-1)'(saturate_u(SAT_W'(boosted), SAT_W'(AMP_MAX)));
    pos_val  = {1'b0, mag_out};
    comp_val = s2_q.data[DATA_W-1] ? (~pos_val + DATA_W'(1)) : pos_val;

    out_d       = out_q;
    out_d.valid = s2_q.valid;
    if (s2_q.valid) begin
      out_d.ch   = s2_q.ch;
      out_d.data = s2_q.enable ? $signed(comp_val) : s2_q.data;
    end
  end

  // Pipeline registers; reset discards everything in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      out_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      out_q <= out_d;
    end
  end

  assign o_data  = out_q.data;
  assign o_valid = out_q.valid;
  assign o_ch    = out_q.ch;

endmodule

// File: tb/tb_effect_dyn_compressor.sv
// Self-checking bench for effect_dyn_compressor: directed scenarios with
// hand-derived constants plus a randomized stream against a behavioural model.
module tb_effect_dyn_compressor;

  localparam int DW     = 16;
  localparam int NUM_CH = 3;
  localparam int CH_W   = 2;
  localparam int ATK    = 2;
  localparam int REL    = 6;
  localparam int MAXV   = 32767;

  logic                 i_clk = 1'b0;
  logic                 i_rst;
  logic                 i_valid;
  logic [CH_W-1:0]      i_ch;
  logic                 i_enable;
  logic [2:0]           i_level;
  logic [1:0]           i_ratio;
  logic                 i_link;
  logic signed [DW-1:0] i_data;
  logic signed [DW-1:0] o_data;
  logic                 o_valid;
  logic [CH_W-1:0]      o_ch;

  int checks   = 0;
  int failures = 0;

  int env_m [NUM_CH];
  int thr_tab [8] = '{28000, 24000, 20000, 16000, 12000, 8000, 4000, 2000};
  int mk_tab  [8] = '{0, 0, 0, 1, 1, 2, 2, 3};

  effect_dyn_compressor #(
    .DATA_W    (DW),
    .NUM_CH    (NUM_CH),
    .ATK_SHIFT (ATK),
    .REL_SHIFT (REL)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .i_ch     (i_ch),
    .i_enable (i_enable),
    .i_level  (i_level),
    .i_ratio  (i_ratio),
    .i_link   (i_link),
    .i_data   (i_data),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .o_ch     (o_ch)
  );

  always #5 i_clk = ~i_clk;

  // Drive one cycle of inputs, advance the reference model, return at the next falling edge.
  task automatic drive(input bit v, input int ch, input int data, input bit en,
                       input int lvl, input int ratio, input bit link, input bit rst,
                       output bit ev, output int ed, output int ech);
    int a, c, e, t, over, red, mag;
    i_rst    = rst;
    i_valid  = v;
    i_ch     = CH_W'(ch);
    i_data   = DW'(data);
    i_enable = en;
    i_level  = 3'(lvl);
    i_ratio  = 2'(ratio);
    i_link   = link;
    ev = 1'b0;
    ed = 0;
    ech = ch;
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) env_m[k] = 0;
    end else if (v && ch < NUM_CH) begin
      a = (data < 0) ? -data : data;
      if (a > MAXV) a = MAXV;
      c = link ? 0 : ch;
      e = env_m[c];
      if (a > e) e = e + (a - e) / (1 << ATK);
      else       e = e - (e - a) / (1 << REL);
      env_m[c] = e;
      if (!en) begin
        ed = data;
      end else begin
        t    = thr_tab[lvl] * (1 << (DW - 16));
        over = (e > t) ? e - t : 0;
        red  = (ratio == 3) ? over : over - over / (1 << (ratio + 1));
        mag  = a - red;
        if (mag < 0) mag = 0;
        mag = mag * (1 << mk_tab[lvl]);
        if (mag > MAXV) mag = MAXV;
        ed = (data < 0) ? -mag : mag;
      end
      ev = 1'b1;
    end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic idle(input int n);
    bit ev; int ed, ech;
    for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 0, 0, ev, ed, ech);
  endtask

  task automatic do_reset();
    bit ev; int ed, ech;
    drive(0, 0, 0, 0, 0, 0, 0, 1, ev, ed, ech);
    drive(0, 0, 0, 0, 0, 0, 0, 1, ev, ed, ech);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (o_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %0b expected 0", o_valid); end
    checks++;
    if (o_data !== '0) begin failures++; $display("[TB] FAIL reset_data: got %0d expected 0", o_data); end
    checks++;
    if (o_ch !== '0) begin failures++; $display("[TB] FAIL reset_ch: got %0d expected 0", o_ch); end
  endtask

  task automatic test_latency_small();
    bit ev; int ed, ech;
    do_reset();
    drive(1, 0, 1000, 1, 0, 1, 0, 0, ev, ed, ech);
    checks++;
    if (o_valid !== 1'b0) begin failures++; $display("[TB] FAIL lat_c1: got %0b expected 0", o_valid); end
    idle(1);
    checks++;
    if (o_valid !== 1'b0) begin failures++; $display("[TB] FAIL lat_c2: got %0b expected 0", o_valid); end
    idle(1);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 16'sd1000 || o_ch !== 2'd0) begin
      failures++; $display("[TB] FAIL lat_c3: got v=%0b d=%0d ch=%0d expected v=1 d=1000 ch=0", o_valid, o_data, o_ch);
    end
    idle(1);
    checks++;
    if (o_valid !== 1'b0 || o_data !== 16'sd1000) begin
      failures++; $display("[TB] FAIL hold: got v=%0b d=%0d expected v=0 d=1000", o_valid, o_data);
    end
    drive(1, 3, 5000, 1, 0, 1, 0, 0, ev, ed, ech);
    idle(2);
    checks++;
    if (o_valid !== 1'b0 || o_data !== 16'sd1000) begin
      failures++; $display("[TB] FAIL bad_channel: got v=%0b d=%0d expected v=0 d=1000", o_valid, o_data);
    end
    for (int k = 0; k < 8; k++) begin
      if (k < 6) drive(1, 0, 1000, 1, 0, 1, 0, 0, ev, ed, ech);
      else idle(1);
      if (k >= 2) begin
        checks++;
        if (o_valid !== 1'b1 || o_data !== 16'sd1000) begin
          failures++; $display("[TB] FAIL stream_small[%0d]: got v=%0b d=%0d expected v=1 d=1000", k, o_valid, o_data);
        end
      end
    end
  endtask

  task automatic test_loud_settle();
    bit ev; int ed, ech;
    do_reset();
    for (int k = 0; k < 60; k++) drive(1, 0, 32000, 1, 0, 1, 0, 0, ev, ed, ech);
    idle(2);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 16'sd29002) begin
      failures++; $display("[TB] FAIL loud_pos: got v=%0b d=%0d expected v=1 d=29002", o_valid, o_data);
    end
    for (int k = 0; k < 3; k++) drive(1, 0, -32000, 1, 0, 1, 0, 0, ev, ed, ech);
    idle(2);
    checks++;
    if (o_valid !== 1'b1 || o_data !== -16'sd29002) begin
      failures++; $display("[TB] FAIL loud_neg: got v=%0b d=%0d expected v=1 d=-29002", o_valid, o_data);
    end
  endtask

  task automatic test_level7();
    bit ev; int ed, ech;
    do_reset();
    drive(1, 0, -20000, 1, 7, 0, 0, 0, ev, ed, ech);
    idle(2);
    checks++;
    if (o_valid !== 1'b1 || o_data !== -16'sd32767) begin
      failures++; $display("[TB] FAIL lvl7_sat: got v=%0b d=%0d expected v=1 d=-32767", o_valid, o_data);
    end
    for (int k = 0; k < 150; k++) drive(1, 0, 100, 1, 7, 0, 0, 0, ev, ed, ech);
    idle(2);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 16'sd800) begin
      failures++; $display("[TB] FAIL lvl7_makeup: got v=%0b d=%0d expected v=1 d=800", o_valid, o_data);
    end
  endtask

  task automatic test_link();
    bit ev; int ed, ech;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      drive(1, 0, 32000, 1, 0, 1, 0, 0, ev, ed, ech);
      drive(1, 1, 1000, 1, 0, 1, 0, 0, ev, ed, ech);
    end
    idle(2);
    checks++;
    if (o_valid !== 1'b1 || o_ch !== 2'd1 || o_data !== 16'sd1000) begin
      failures++; $display("[TB] FAIL unlinked_ch1: got v=%0b ch=%0d d=%0d expected v=1 ch=1 d=1000", o_valid, o_ch, o_data);
    end
    for (int k = 0; k < 40; k++) begin
      drive(1, 0, 32000, 1, 0, 1, 1, 0, ev, ed, ech);
      drive(1, 1, 1000, 1, 0, 1, 1, 0, ev, ed, ech);
    end
    idle(2);
    checks++;
    if (o_valid !== 1'b1 || o_ch !== 2'd1 || o_data !== 16'sd0) begin
      failures++; $display("[TB] FAIL linked_ch1: got v=%0b ch=%0d d=%0d expected v=1 ch=1 d=0", o_valid, o_ch, o_data);
    end
  endtask

  task automatic test_most_negative();
    bit ev; int ed, ech;
    do_reset();
    drive(1, 0, -32768, 0, 0, 0, 0, 0, ev, ed, ech);
    idle(2);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 16'h8000) begin
      failures++; $display("[TB] FAIL bypass_minneg: got v=%0b d=%0d expected v=1 d=-32768", o_valid, o_data);
    end
    do_reset();
    drive(1, 0, -32768, 1, 0, 0, 0, 0, ev, ed, ech);
    idle(2);
    checks++;
    if (o_valid !== 1'b1 || o_data !== -16'sd32767) begin
      failures++; $display("[TB] FAIL comp_minneg: got v=%0b d=%0d expected v=1 d=-32767", o_valid, o_data);
    end
  endtask

  task automatic test_reset_inflight();
    bit ev; int ed, ech;
    do_reset();
    for (int k = 0; k < 12; k++) drive(1, 0, 30000, 1, 7, 0, 0, 0, ev, ed, ech);
    drive(1, 0, 30000, 1, 7, 0, 0, 1, ev, ed, ech);
    checks++;
    if (o_valid !== 1'b0 || o_data !== 16'sd0) begin
      failures++; $display("[TB] FAIL inflight_rst: got v=%0b d=%0d expected v=0 d=0", o_valid, o_data);
    end
    for (int k = 0; k < 4; k++) begin
      idle(1);
      checks++;
      if (o_valid !== 1'b0) begin failures++; $display("[TB] FAIL inflight_after[%0d]: got %0b expected 0", k, o_valid); end
    end
    drive(1, 0, 4000, 1, 7, 0, 0, 0, ev, ed, ech);
    idle(2);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 16'sd32000) begin
      failures++; $display("[TB] FAIL fresh_env: got v=%0b d=%0d expected v=1 d=32000", o_valid, o_data);
    end
  endtask

  task automatic test_random();
    bit hv[$];
    int hd[$];
    int hc[$];
    int hold, idx, data;
    bit ev, rst;
    int ed, ech;
    hold = 0;
    for (int k = 0; k < 600; k++) begin
      rst  = (k == 0) || ($urandom_range(0, 99) == 0);
      data = ($urandom_range(0, 15) == 0) ? -32768 : int'($urandom_range(0, 65535)) - 32768;
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), data,
            $urandom_range(0, 4) != 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
            $urandom_range(0, 3) == 0, rst, ev, ed, ech);
      if (rst) begin
        for (int j = 0; j < hv.size(); j++) hv[j] = 1'b0;
        hold = 0;
      end
      hv.push_back(ev);
      hd.push_back(ed);
      hc.push_back(ech);
      if (hv.size() >= 3) begin
        idx = hv.size() - 3;
        checks++;
        if (hv[idx]) begin
          if (o_valid !== 1'b1 || $signed(o_data) !== hd[idx] || o_ch !== CH_W'(hc[idx])) begin
            failures++;
            $display("[TB] FAIL random[%0d]: got v=%0b d=%0d ch=%0d expected v=1 d=%0d ch=%0d",
                     k, o_valid, o_data, o_ch, hd[idx], hc[idx]);
          end
          hold = hd[idx];
        end else if (o_valid !== 1'b0 || $signed(o_data) !== hold) begin
          failures++;
          $display("[TB] FAIL random_idle[%0d]: got v=%0b d=%0d expected v=0 d=%0d", k, o_valid, o_data, hold);
        end
      end
    end
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_ch = '0; i_enable = 1'b0;
    i_level = '0; i_ratio = '0; i_link = 1'b0; i_data = '0;
    for (int k = 0; k < NUM_CH; k++) env_m[k] = 0;
    test_reset();
    test_latency_small();
    test_loud_settle();
    test_level7();
    test_link();
    test_most_negative();
    test_reset_inflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
